// File: rtl/mem_pkg.sv
// Shared constants and types for the byte-wide memory responder (byte_mem_resp).
package mem_pkg;

  localparam int unsigned DATA_L_DEF = 8;
  localparam int unsigned ADDR_L_DEF = 32;
  localparam int unsigned MEM_AW_DEF = 16;
  localparam int unsigned RD_LAT_MAX = 4;

  typedef logic [DATA_L_DEF-1:0] mem_byte_t;
  typedef logic [ADDR_L_DEF-1:0] mem_addr_t;

endpackage : mem_pkg

// File: rtl/byte_mem_resp_rd_pipe.sv
// rd_pipe: RD_LAT-stage read-return shift register carrying {valid, err, data}.
// Only valid/err bits and the visible output data stage are reset.
module rd_pipe #(
  parameter int unsigned DATA_L = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_L-1:0] in_data,
  input  logic              merge_err,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_L-1:0] out_data,
  output logic              busy
);

  logic [RD_LAT-1:0]             vld_q, vld_d;
  logic [RD_LAT-1:0]             err_q, err_d;
  logic [RD_LAT-1:0][DATA_L-1:0] dat_q, dat_d;
  logic                          busy_q, busy_d;

  // Shift one stage per clock; data only moves with a valid entry so the
  // output stage holds the last returned byte between reads.
  always_comb begin : next_stage
    vld_d    = '0;
    err_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = in_valid;
    err_d[0] = in_valid & in_err;
    if (in_valid) begin
      dat_d[0] = in_data;
    end
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      if (vld_q[i-1]) begin
        dat_d[i] = dat_q[i-1];
      end
    end
    // Write-side error joins at the output stage so m_err is a single flop.
    err_d[RD_LAT-1] = err_d[RD_LAT-1] | merge_err;
    busy_d          = |vld_d;
  end

  always_ff @(posedge clk or posedge rst) begin : ctrl_reg
    if (rst) begin
      vld_q  <= '0;
      err_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < int'(RD_LAT); g++) begin : g_stage
    logic [DATA_L-1:0] data_q;
    if (g == int'(RD_LAT) - 1) begin : g_out
      // Output stage is visible as m_rdata and must read 0 out of reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q <= '0;
        end else begin
          data_q <= dat_d[g];
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        data_q <= dat_d[g];
      end
    end
    assign dat_q[g] = data_q;
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_err   = err_q[RD_LAT-1];
  assign out_data  = dat_q[RD_LAT-1];
  assign busy      = busy_q;

endmodule : rd_pipe

// File: rtl/byte_mem_resp.sv
// byte_mem_resp: byte-wide memory responder with pipelined fixed-latency reads.
// Optional address bound check enabled by defining MEM_BOUND_CHK_EN.
module byte_mem_resp
  import mem_pkg::*;
#(
  parameter int unsigned DATA_L = DATA_L_DEF,
  parameter int unsigned ADDR_L = ADDR_L_DEF,
  parameter int unsigned MEM_AW = MEM_AW_DEF,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_re,
  input  logic [ADDR_L-1:0] m_raddr,
  input  logic              m_we,
  input  logic [ADDR_L-1:0] m_waddr,
  input  logic [DATA_L-1:0] m_wdata,
  output logic [DATA_L-1:0] m_rdata,
  output logic              m_rvalid,
  output logic              m_wack,
  output logic              m_busy,
  output logic              m_err
);

  localparam int unsigned DEPTH = 2 ** MEM_AW;

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("byte_mem_resp: RD_LAT must be in 1..%0d", RD_LAT_MAX);
  end

  logic [DATA_L-1:0] mem_q [DEPTH];
  logic [MEM_AW-1:0] rd_idx_c, wr_idx_c;
  logic              rd_oor_c, wr_oor_c;
  logic              wr_en_c, wr_err_c;
  logic [DATA_L-1:0] rd_data_c;
  logic              wack_q, wack_d;

  // Low address bits index the array; high bits are range-checked or ignored.
  always_comb begin : addr_map
    rd_idx_c = m_raddr[MEM_AW-1:0];
    wr_idx_c = m_waddr[MEM_AW-1:0];
`ifdef MEM_BOUND_CHK_EN
    rd_oor_c = |m_raddr[ADDR_L-1:MEM_AW];
    wr_oor_c = |m_waddr[ADDR_L-1:MEM_AW];
`else
    rd_oor_c = 1'b0;
    wr_oor_c = 1'b0;
`endif
  end

`ifndef MEM_BOUND_CHK_EN
  logic [2*(ADDR_L-MEM_AW)-1:0] unused_addr_hi;
  assign unused_addr_hi = {m_raddr[ADDR_L-1:MEM_AW], m_waddr[ADDR_L-1:MEM_AW]};
`endif

  // Read samples the array before this edge's write lands: read-before-write.
  always_comb begin : access_ctrl
    rd_data_c = rd_oor_c ? '0 : mem_q[rd_idx_c];
    wr_en_c   = m_we & ~wr_oor_c;
    wr_err_c  = m_we & wr_oor_c;
    wack_d    = m_we;
  end

  always_ff @(posedge clk) begin : mem_write
    if (wr_en_c) begin
      mem_q[wr_idx_c] <= m_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : wack_reg
    if (rst) begin
      wack_q <= 1'b0;
    end else begin
      wack_q <= wack_d;
    end
  end

  rd_pipe #(
    .DATA_L (DATA_L),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_re),
    .in_err    (rd_oor_c),
    .in_data   (rd_data_c),
    .merge_err (wr_err_c),
    .out_valid (m_rvalid),
    .out_err   (m_err),
    .out_data  (m_rdata),
    .busy      (m_busy)
  );

  assign m_wack = wack_q;

endmodule : byte_mem_resp
